// File: rtl/serial_link_peer_if.sv
// serial_link_peer_if
//   Signal bundle between the link-cable peer model and whatever drives it.
//   The slave modport is the peer's view; the master modport is the view of
//   the environment that plays the DMG side and issues peer commands.
//
//   sck_in      DMG serial clock as seen on the cable
//   sout_in     DMG serial out (SO), sampled by the peer
//   sin_out     peer serial data toward DMG SI
//   sck_out     serial clock generated by the peer
//   sck_oe      peer is driving SCK
//   master_mode 0 = follow sck_in, 1 = peer generates the clock
//   start       one-cycle pulse, begins a master-mode transfer
//   tx_data     next byte to send
//   tx_load     one-cycle pulse, latches tx_data
//   rx_data     last complete byte received
//   rx_valid    one-cycle pulse when rx_data updates
//   busy        transfer in progress
interface serial_link_peer_if;
  logic       sck_in;
  logic       sout_in;
  logic       sin_out;
  logic       sck_out;
  logic       sck_oe;
  logic       master_mode;
  logic       start;
  logic [7:0] tx_data;
  logic       tx_load;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;

  modport slave (
    input  sck_in, sout_in, master_mode, start, tx_data, tx_load,
    output sin_out, sck_out, sck_oe, rx_data, rx_valid, busy
  );

  modport master (
    output sck_in, sout_in, master_mode, start, tx_data, tx_load,
    input  sin_out, sck_out, sck_oe, rx_data, rx_valid, busy
  );
endinterface

// File: rtl/serial_link_peer.sv
// serial_link_peer
//   Cycle-based model of the device at the far end of the DMG link cable.
//   Exchanges one byte per transfer, MSB first. In slave mode it follows the
//   DMG's SCK (through a 2-flop synchronizer); in master mode it generates
//   SCK itself with SCK_HALF clk cycles per half period.
//
//   clk   sampling clock, all state changes on its rising edge
//   nrst  asynchronous active-low reset
//   link  serial_link_peer_if.slave, see the interface file for signals
module serial_link_peer #(
  parameter int unsigned SCK_HALF  = 256,
  parameter logic [7:0]  IDLE_BYTE = 8'hFF
) (
  input logic               clk,
  input logic               nrst,
  serial_link_peer_if.slave link
);

  localparam int unsigned           HALF_W    = $clog2(SCK_HALF);
  localparam logic [HALF_W-1:0]     HALF_LAST = HALF_W'(SCK_HALF - 1);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_SHIFT    = 2'd1;
  localparam logic [1:0] ST_RUN_LOW  = 2'd2;
  localparam logic [1:0] ST_RUN_HIGH = 2'd3;

  logic [1:0]        state_q,   state_d;
  logic [7:0]        shreg_q,   shreg_d;
  logic [2:0]        bitcnt_q,  bitcnt_d;
  logic [HALF_W-1:0] halfCnt_q, halfCnt_d;
  logic              sinOut_q,  sinOut_d;
  logic [7:0]        held_q,    held_d;
  logic              pending_q, pending_d;
  logic [7:0]        rxData_q,  rxData_d;
  logic              rxValid_q, rxValid_d;
  logic              syncA_q, syncB_q, sckPrev_q;

  logic       sckRise, sckFall;
  logic       doRise, doFall, abort, completing;
  logic [7:0] shifted;

  // Edges are taken from the synchronized SCK only; the flops reset high to
  // match an idle (high) clock line so release of reset creates no edge.
  assign sckRise = syncB_q & ~sckPrev_q;
  assign sckFall = ~syncB_q & sckPrev_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      syncA_q   <= 1'b1;
      syncB_q   <= 1'b1;
      sckPrev_q <= 1'b1;
    end else begin
      syncA_q   <= link.sck_in;
      syncB_q   <= syncA_q;
      sckPrev_q <= syncB_q;
    end
  end

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bitcnt_d   = bitcnt_q;
    halfCnt_d  = halfCnt_q;
    sinOut_d   = sinOut_q;
    held_d     = held_q;
    pending_d  = pending_q;
    rxData_d   = rxData_q;
    rxValid_d  = 1'b0;
    doRise     = 1'b0;
    doFall     = 1'b0;
    abort      = 1'b0;
    completing = 1'b0;
    shifted    = {shreg_q[6:0], link.sout_in};

    case (state_q)
      ST_IDLE: begin
        // Keep the registered bit in step with shreg[7] so leaving IDLE
        // never glitches sin_out.
        sinOut_d = shreg_q[7];
        if (link.master_mode) begin
          if (link.start) begin
            state_d   = ST_RUN_LOW;
            halfCnt_d = '0;
          end
        end else if (sckRise || sckFall) begin
          state_d = ST_SHIFT;
          doRise  = sckRise;
        end
      end
      ST_SHIFT: begin
        if (link.master_mode) begin
          abort = 1'b1;
        end else begin
          doRise = sckRise;
          doFall = sckFall;
        end
      end
      ST_RUN_LOW: begin
        if (!link.master_mode) begin
          abort = 1'b1;
        end else if (halfCnt_q == HALF_LAST) begin
          state_d   = ST_RUN_HIGH;
          halfCnt_d = '0;
          doRise    = 1'b1;
        end else begin
          halfCnt_d = halfCnt_q + HALF_W'(1);
        end
      end
      ST_RUN_HIGH: begin
        if (!link.master_mode) begin
          abort = 1'b1;
        end else if (halfCnt_q == HALF_LAST) begin
          halfCnt_d = '0;
          // bitcnt has wrapped to 0 only after the 8th sample
          if (bitcnt_q == 3'd0) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_RUN_LOW;
            doFall  = 1'b1;
          end
        end else begin
          halfCnt_d = halfCnt_q + HALF_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (doFall) begin
      sinOut_d = shreg_q[7];
    end

    if (doRise) begin
      shreg_d  = shifted;
      bitcnt_d = bitcnt_q + 3'd1;
      if (bitcnt_q == 3'd7) begin
        completing = 1'b1;
        rxData_d   = shifted;
        rxValid_d  = 1'b1;
        shreg_d    = pending_q ? held_q : IDLE_BYTE;
        pending_d  = 1'b0;
        // Master mode still owes the last high phase before going idle.
        if (!state_q[1]) begin
          state_d = ST_IDLE;
        end
      end
    end

    // A mode change mid-transfer drops the byte; shreg keeps its partial
    // contents by design.
    if (abort) begin
      state_d   = ST_IDLE;
      bitcnt_d  = '0;
      halfCnt_d = '0;
    end

    // Loads go straight into shreg whenever no bits of a transfer remain
    // to be shifted; otherwise they wait in held_q for the transfer end.
    if (link.tx_load) begin
      if (state_q == ST_IDLE || completing ||
          (state_q == ST_RUN_HIGH && bitcnt_q == 3'd0)) begin
        shreg_d = link.tx_data;
      end else begin
        held_d    = link.tx_data;
        pending_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= ST_IDLE;
      shreg_q   <= IDLE_BYTE;
      bitcnt_q  <= '0;
      halfCnt_q <= '0;
      sinOut_q  <= 1'b1;
      held_q    <= IDLE_BYTE;
      pending_q <= 1'b0;
      rxData_q  <= 8'h00;
      rxValid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bitcnt_q  <= bitcnt_d;
      halfCnt_q <= halfCnt_d;
      sinOut_q  <= sinOut_d;
      held_q    <= held_d;
      pending_q <= pending_d;
      rxData_q  <= rxData_d;
      rxValid_q <= rxValid_d;
    end
  end

  assign link.sin_out  = (state_q == ST_IDLE) ? shreg_q[7] : sinOut_q;
  assign link.sck_oe   = state_q[1];
  assign link.sck_out  = (state_q != ST_RUN_LOW);
  assign link.rx_data  = rxData_q;
  assign link.rx_valid = rxValid_q;
  assign link.busy     = (bitcnt_q != 3'd0) || state_q[1];

endmodule
